// File: rtl/fb_pkg.sv
// Shared types and default geometry for the frame-buffer pattern writer and its pixel function.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fb_pkg;

  localparam int FB_W_DEF      = 320;
  localparam int FB_H_DEF      = 240;
  localparam int X_BITS_DEF    = 9;
  localparam int Y_BITS_DEF    = 9;
  localparam int PIX_BITS_DEF  = 4;
  localparam int BAR_SHIFT_DEF = 4;
  // Width of the animation x-offset register.
  localparam int OFS_BITS      = 8;

  typedef enum logic [2:0] {
    PAT_SOLID    = 3'd0,
    PAT_HBARS    = 3'd1,
    PAT_VBARS    = 3'd2,
    PAT_CHECKER  = 3'd3,
    PAT_GRADIENT = 3'd4
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } fill_state_e;

endpackage

// File: rtl/fb_pattern_pixel.sv
// Test-pattern pixel function: (mode, x, y, offset, fg, bg) -> palette index.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller registers the result.
module fb_pattern_pixel
  import fb_pkg::*;
#(
  parameter int X_BITS    = X_BITS_DEF,
  parameter int Y_BITS    = Y_BITS_DEF,
  parameter int PIX_BITS  = PIX_BITS_DEF,
  parameter int BAR_SHIFT = BAR_SHIFT_DEF
) (
  input  logic [2:0]          i_mode,
  input  logic [X_BITS-1:0]   i_x,
  input  logic [Y_BITS-1:0]   i_y,
  input  logic [OFS_BITS-1:0] i_offset,
  input  logic [PIX_BITS-1:0] i_fg,
  input  logic [PIX_BITS-1:0] i_bg,
  output logic [PIX_BITS-1:0] o_pixel
);

  // Sum is formed wide enough for either operand, then wrapped to the x width.
  localparam int SUM_BITS = (X_BITS > OFS_BITS) ? X_BITS : OFS_BITS;

  logic [SUM_BITS-1:0] w_sum;
  logic [X_BITS-1:0]   w_xe;
  logic                w_xbar;
  logic                w_ybar;
  logic                w_unused;

  assign w_sum    = SUM_BITS'(i_x) + SUM_BITS'(i_offset);
  assign w_xe     = w_sum[X_BITS-1:0];
  assign w_xbar   = w_xe[BAR_SHIFT];
  assign w_ybar   = i_y[BAR_SHIFT];
  // Only selected bits of y and the sum feed the patterns.
  assign w_unused = ^{w_sum, i_y};

  // Select the pattern; reserved codes fall back to background.
  always_comb begin
    o_pixel = i_bg;
    case (i_mode)
      PAT_SOLID:    o_pixel = i_fg;
      PAT_HBARS:    o_pixel = w_ybar ? i_fg : i_bg;
      PAT_VBARS:    o_pixel = w_xbar ? i_fg : i_bg;
      PAT_CHECKER:  o_pixel = (w_xbar ^ w_ybar) ? i_fg : i_bg;
      PAT_GRADIENT: o_pixel = w_xe[BAR_SHIFT +: PIX_BITS];
      default:      o_pixel = i_bg;
    endcase
  end

endmodule

// File: rtl/fb_pattern_writer.sv
// Frame-buffer fill engine: on start writes a full frame in raster order with a test pattern.
// Latency: first write presented the cycle after start; one write per cycle at full rate; done one cycle after last accept.
// Backpressure: gpu_we/gpu_ready handshake; x/y/data held while !gpu_ready. FB_PATTERN_ANIM_EN enables auto-restart with x-offset.
module fb_pattern_writer
  import fb_pkg::*;
#(
  parameter int FB_W      = FB_W_DEF,
  parameter int FB_H      = FB_H_DEF,
  parameter int X_BITS    = X_BITS_DEF,
  parameter int Y_BITS    = Y_BITS_DEF,
  parameter int PIX_BITS  = PIX_BITS_DEF,
  parameter int BAR_SHIFT = BAR_SHIFT_DEF
) (
  input  logic                gpu_clk_150,
  input  logic                reset_n,
  input  logic                start,
  input  logic [2:0]          mode,
  input  logic [PIX_BITS-1:0] fg_colour,
  input  logic [PIX_BITS-1:0] bg_colour,
  input  logic                gpu_ready,
  output logic [X_BITS-1:0]   gpu_x,
  output logic [Y_BITS-1:0]   gpu_y,
  output logic [PIX_BITS-1:0] gpu_data,
  output logic                gpu_we,
  output logic                busy,
  output logic                done
);

  fill_state_e         r_state;
  logic [X_BITS-1:0]   r_x;
  logic [Y_BITS-1:0]   r_y;
  logic [PIX_BITS-1:0] r_data;
  logic                r_we;
  logic                r_busy;
  logic                r_done;
  logic [2:0]          r_mode;
  logic [PIX_BITS-1:0] r_fg;
  logic [PIX_BITS-1:0] r_bg;

  logic [OFS_BITS-1:0] w_offset;
`ifdef FB_PATTERN_ANIM_EN
  logic [OFS_BITS-1:0] r_offset;
  assign w_offset = r_offset;
`else
  assign w_offset = '0;
`endif

  logic                w_accept;
  logic                w_last_x;
  logic                w_last;
  logic [X_BITS-1:0]   w_adv_x;
  logic [Y_BITS-1:0]   w_adv_y;
  logic [X_BITS-1:0]   w_px_x;
  logic [Y_BITS-1:0]   w_px_y;
  logic [2:0]          w_px_mode;
  logic [PIX_BITS-1:0] w_px_fg;
  logic [PIX_BITS-1:0] w_px_bg;
  logic [PIX_BITS-1:0] w_pixel;

  assign w_accept = r_we & gpu_ready;
  assign w_last_x = (r_x == X_BITS'(FB_W - 1));
  assign w_last   = w_last_x && (r_y == Y_BITS'(FB_H - 1));
  assign w_adv_x  = w_last_x ? '0 : r_x + X_BITS'(1);
  assign w_adv_y  = w_last_x ? r_y + Y_BITS'(1) : r_y;

  // Pixel for the coordinate about to be registered: origin when (re)starting,
  // raster successor while filling; a fresh start uses the unlatched inputs.
  always_comb begin
    w_px_x    = w_adv_x;
    w_px_y    = w_adv_y;
    w_px_mode = r_mode;
    w_px_fg   = r_fg;
    w_px_bg   = r_bg;
    if (r_state != ST_FILL) begin
      w_px_x = '0;
      w_px_y = '0;
    end
    if (r_state == ST_IDLE) begin
      w_px_mode = mode;
      w_px_fg   = fg_colour;
      w_px_bg   = bg_colour;
    end
  end

  fb_pattern_pixel #(
    .X_BITS    (X_BITS),
    .Y_BITS    (Y_BITS),
    .PIX_BITS  (PIX_BITS),
    .BAR_SHIFT (BAR_SHIFT)
  ) u_pixel (
    .i_mode   (w_px_mode),
    .i_x      (w_px_x),
    .i_y      (w_px_y),
    .i_offset (w_offset),
    .i_fg     (w_px_fg),
    .i_bg     (w_px_bg),
    .o_pixel  (w_pixel)
  );

  // Fill FSM with all outputs registered.
  always_ff @(posedge gpu_clk_150) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_data   <= '0;
      r_we     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mode   <= '0;
      r_fg     <= '0;
      r_bg     <= '0;
`ifdef FB_PATTERN_ANIM_EN
      r_offset <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_FILL;
            r_mode  <= mode;
            r_fg    <= fg_colour;
            r_bg    <= bg_colour;
            r_x     <= '0;
            r_y     <= '0;
            r_data  <= w_pixel;
            r_we    <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_FILL: begin
          if (w_accept) begin
            if (w_last) begin
              r_state  <= ST_DONE;
              r_we     <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
`ifdef FB_PATTERN_ANIM_EN
              // Next frame's first pixel sees the advanced offset.
              r_offset <= r_offset + OFS_BITS'(1);
`endif
            end else begin
              r_x    <= w_adv_x;
              r_y    <= w_adv_y;
              r_data <= w_pixel;
            end
          end
        end
        ST_DONE: begin
`ifdef FB_PATTERN_ANIM_EN
          r_state <= ST_FILL;
          r_x     <= '0;
          r_y     <= '0;
          r_data  <= w_pixel;
          r_we    <= 1'b1;
          r_busy  <= 1'b1;
`else
          r_state <= ST_IDLE;
`endif
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gpu_x    = r_x;
  assign gpu_y    = r_y;
  assign gpu_data = r_data;
  assign gpu_we   = r_we;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_fb_pattern_writer.sv
// Scoreboard bench for fb_pattern_writer on an 8x2 frame with 2-pixel bars.
// Latency: n/a.
// Backpressure: gpu_ready driven by directed stimulus.
module tb_fb_pattern_writer;

  localparam int FB_W      = 8;
  localparam int FB_H      = 2;
  localparam int X_BITS    = 5;
  localparam int Y_BITS    = 2;
  localparam int PIX_BITS  = 4;
  localparam int BAR_SHIFT = 1;

  logic                gpu_clk_150 = 1'b0;
  logic                reset_n;
  logic                start;
  logic [2:0]          mode;
  logic [PIX_BITS-1:0] fg_colour;
  logic [PIX_BITS-1:0] bg_colour;
  logic                gpu_ready;
  logic [X_BITS-1:0]   gpu_x;
  logic [Y_BITS-1:0]   gpu_y;
  logic [PIX_BITS-1:0] gpu_data;
  logic                gpu_we;
  logic                busy;
  logic                done;

  always #5 gpu_clk_150 = ~gpu_clk_150;

  fb_pattern_writer #(
    .FB_W      (FB_W),
    .FB_H      (FB_H),
    .X_BITS    (X_BITS),
    .Y_BITS    (Y_BITS),
    .PIX_BITS  (PIX_BITS),
    .BAR_SHIFT (BAR_SHIFT)
  ) dut (
    .gpu_clk_150 (gpu_clk_150),
    .reset_n     (reset_n),
    .start       (start),
    .mode        (mode),
    .fg_colour   (fg_colour),
    .bg_colour   (bg_colour),
    .gpu_ready   (gpu_ready),
    .gpu_x       (gpu_x),
    .gpu_y       (gpu_y),
    .gpu_data    (gpu_data),
    .gpu_we      (gpu_we),
    .busy        (busy),
    .done        (done)
  );

  typedef struct packed {
    logic [X_BITS-1:0]   x;
    logic [Y_BITS-1:0]   y;
    logic [PIX_BITS-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  done_cnt = 0;
  int  cyc = 0;
  int  last_acc_cyc = -10;
  bit  prev_stall = 1'b0;
  wr_t prev_w;

  task automatic check(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(posedge gpu_clk_150) cyc <= cyc + 1;

  // Monitor: pops one expected write per accepted handshake.
  always @(negedge gpu_clk_150) begin
    wr_t cur;
    wr_t e;
    cur = {gpu_x, gpu_y, gpu_data};
    if (done) done_cnt++;
    if (prev_stall && gpu_we) check("stall_hold", int'(cur), int'(prev_w));
    if (gpu_we && gpu_ready) begin
      last_acc_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got x=%0d y=%0d d=%0h, no write expected", gpu_x, gpu_y, gpu_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_x", int'(gpu_x), int'(e.x));
        check("wr_y", int'(gpu_y), int'(e.y));
        check("wr_data", int'(gpu_data), int'(e.d));
      end
    end
    prev_stall = gpu_we && !gpu_ready;
    prev_w     = cur;
  end

  // Row tables hold nibble x at bits [4x+3:4x].
  task automatic push_frame(input logic [31:0] r0, input logic [31:0] r1, input int n);
    for (int i = 0; i < n; i++) begin
      int          px;
      int          py;
      logic [31:0] r;
      px = i % FB_W;
      py = i / FB_W;
      r  = (py == 0) ? r0 : r1;
      exp_q.push_back({X_BITS'(px), Y_BITS'(py), r[px*4 +: 4]});
    end
  endtask

  task automatic pulse_start(input logic [2:0] m, input logic [3:0] f, input logic [3:0] b);
    @(posedge gpu_clk_150);
    #1;
    mode = m; fg_colour = f; bg_colour = b; start = 1'b1;
    @(posedge gpu_clk_150);
    #1 start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string nm);
    check({nm, "_x"},    int'(gpu_x), 0);
    check({nm, "_y"},    int'(gpu_y), 0);
    check({nm, "_data"}, int'(gpu_data), 0);
    check({nm, "_we"},   int'(gpu_we), 0);
    check({nm, "_busy"}, int'(busy), 0);
    check({nm, "_done"}, int'(done), 0);
  endtask

  // Waits for done; keep=0 returns an auto-restarting build to IDLE via reset.
  task automatic wait_done(input bit keep);
    int n;
    n = 0;
    do begin
      @(negedge gpu_clk_150);
      n++;
    end while (!done && n < 300);
    if (!done) begin
      check("done_seen", int'(done), 1);
    end else begin
      check("done_latency", cyc - last_acc_cyc, 1);
      check("we_after_last", int'(gpu_we), 0);
      check("busy_in_done", int'(busy), 0);
      check("queue_drained", exp_q.size(), 0);
      if (!keep) begin
`ifdef FB_PATTERN_ANIM_EN
        reset_n = 1'b0;
        @(posedge gpu_clk_150);
        #1 reset_n = 1'b1;
`endif
      end
    end
  endtask

  task automatic check_done_clear();
    @(negedge gpu_clk_150);
    check("done_pulse_width", int'(done), 0);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset_n = 1'b0; start = 1'b1; mode = 3'd0;
    fg_colour = '0; bg_colour = '0; gpu_ready = 1'b1;
    repeat (3) @(posedge gpu_clk_150);
    @(negedge gpu_clk_150);
    check_outputs_zero("reset");
    start = 1'b0;
    @(posedge gpu_clk_150);
    #1 reset_n = 1'b1;

    // SOLID fg=A: first write the cycle after start.
    push_frame(32'hAAAAAAAA, 32'hAAAAAAAA, 16);
    pulse_start(3'd0, 4'hA, 4'h3);
    @(negedge gpu_clk_150);
    check("first_we", int'(gpu_we), 1);
    check("first_busy", int'(busy), 1);
    wait_done(1'b0);
    check_done_clear();

    // VBARS fg=F bg=0: 0,0,F,F,0,0,F,F per row.
    push_frame(32'hFF00FF00, 32'hFF00FF00, 16);
    pulse_start(3'd2, 4'hF, 4'h0);
    wait_done(1'b0);
    check_done_clear();

    // CHECKER with 3-cycle stall on the third write.
    push_frame(32'h55995599, 32'h55995599, 16);
    pulse_start(3'd3, 4'h5, 4'h9);
    @(posedge gpu_clk_150);
    @(posedge gpu_clk_150);
    #1 gpu_ready = 1'b0;
    repeat (3) @(posedge gpu_clk_150);
    #1 gpu_ready = 1'b1;
    wait_done(1'b0);
    check_done_clear();

    // Start mid-fill is ignored: frame stays SOLID 7, single done.
    d0 = done_cnt;
    push_frame(32'h77777777, 32'h77777777, 16);
    pulse_start(3'd0, 4'h7, 4'h1);
    repeat (4) @(posedge gpu_clk_150);
    #1 mode = 3'd3; fg_colour = 4'h1; bg_colour = 4'h2; start = 1'b1;
    @(posedge gpu_clk_150);
    #1 start = 1'b0;
    wait_done(1'b0);
    check_done_clear();
    repeat (4) @(negedge gpu_clk_150);
    #1;
    check("single_done", done_cnt - d0, 1);
    check("idle_we", int'(gpu_we), 0);

    // Reset after exactly 5 accepts, then a fresh frame from the origin.
    gpu_ready = 1'b0;
    push_frame(32'h44444444, 32'h44444444, 5);
    pulse_start(3'd0, 4'h4, 4'h0);
    gpu_ready = 1'b1;
    repeat (5) @(posedge gpu_clk_150);
    #1 gpu_ready = 1'b0;
    check("five_accepts", exp_q.size(), 0);
    @(negedge gpu_clk_150);
    reset_n = 1'b0;
    @(posedge gpu_clk_150);
    #1 reset_n = 1'b1;
    @(negedge gpu_clk_150);
    check_outputs_zero("abort");
    gpu_ready = 1'b1;
    push_frame(32'hBBBBBBBB, 32'hBBBBBBBB, 16);
    pulse_start(3'd0, 4'hB, 4'h0);
    wait_done(1'b0);
    check_done_clear();

    // Reserved mode and HBARS (y[1]=0 on both rows) give background.
    push_frame(32'hCCCCCCCC, 32'hCCCCCCCC, 16);
    pulse_start(3'd6, 4'h1, 4'hC);
    wait_done(1'b0);
    check_done_clear();
    push_frame(32'h22222222, 32'h22222222, 16);
    pulse_start(3'd1, 4'h1, 4'h2);
    wait_done(1'b0);
    check_done_clear();

    // GRADIENT: pixel = xe[4:1].
    d0 = done_cnt;
    push_frame(32'h33221100, 32'h33221100, 16);
    pulse_start(3'd4, 4'h5, 4'h6);
`ifdef FB_PATTERN_ANIM_EN
    wait_done(1'b1);
    push_frame(32'h43322110, 32'h43322110, 16);
    check_done_clear();
    check("restart_busy", int'(busy), 1);
    wait_done(1'b1);
    push_frame(32'h44332211, 32'h44332211, 16);
    check_done_clear();
    wait_done(1'b0);
    check_done_clear();
    repeat (3) @(negedge gpu_clk_150);
    #1;
    check("anim_done_count", done_cnt - d0, 3);
`else
    wait_done(1'b0);
    check_done_clear();
    repeat (5) @(negedge gpu_clk_150);
    #1;
    check("no_restart_we", int'(gpu_we), 0);
    check("no_restart_busy", int'(busy), 0);
    check("grad_done_count", done_cnt - d0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
